alu_sequencer: RTL

- Multi-cycle controller and 4x8-bit register file sitting directly upstream of the 8-bit ALU. Also captures the ALU's result and flags.
- Accepts one 17-bit instruction per valid/ready handshake.
- Drives the ALU operand and function inputs (A, B, F) from registers.
- Writes ALU output C back to the destination register and latches ALU flags.
- Fixed 4-cycle sequence per instruction.

---
 rtl/alu_sequencer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer with a small register file, feeding an external
// combinational ALU and capturing its result and flags.
//
// state     | meaning
// IDLE      | instr_ready high, waiting for instr_valid
// DECODE    | latched instruction selects operands and function for the ALU
// EXECUTE   | ALU inputs stable; result or immediate written on the exiting edge
// WRITEBACK | done high for one cycle, new register value already visible
module alu_sequencer #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 4,
    localparam int AW    = $clog2(NREGS),
    localparam int IW    = 1 + 4 + 2 * AW + DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [3:0]        alu_F,
    input  logic [DATA_W-1:0] alu_C,
    input  logic [1:0]        alu_flags,
    output logic [1:0]        flags_q,
    output logic              done,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IW-1:0]     instr_q;
    logic [DATA_W-1:0] regs [NREGS];

    logic              load_imm;
    logic [3:0]        func;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs;
    logic [DATA_W-1:0] imm;

    assign load_imm = instr_q[IW-1];
    assign func     = instr_q[IW-2 -: 4];
    assign rd       = instr_q[DATA_W+2*AW-1 -: AW];
    assign rs       = instr_q[DATA_W+AW-1 -: AW];
    assign imm      = instr_q[DATA_W-1:0];

    assign rd_data  = regs[rd_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = DECODE;
                end
            end
            DECODE:    state_d = EXECUTE;
            EXECUTE:   state_d = WRITEBACK;
            WRITEBACK: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    // Operands load even for immediate loads; the ALU result is simply ignored then.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            alu_A   <= '0;
            alu_B   <= '0;
            alu_F   <= '0;
            flags_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                    end
                end
                DECODE: begin
                    alu_A <= regs[rd];
                    alu_B <= regs[rs];
                    alu_F <= func;
                end
                EXECUTE: begin
                    if (load_imm) begin
                        regs[rd] <= imm;
                    end else begin
                        regs[rd] <= alu_C;
                        flags_q  <= alu_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
